// File: rtl/priority_rr_scheduler_pkg.sv
// Shared definitions for the priority round-robin scheduler: FSM state
// encoding and default configuration constants.
package priority_rr_scheduler_pkg;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_PRIO_W  = 4;
   localparam int DEF_QUANTUM = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      RUN  = 2'd2
   } sched_state_e;

endpackage

// File: rtl/priority_rr_scheduler_pick.sv
// prio_rr_pick: combinational selector returning the highest-priority
// requester, ties resolved by the first candidate at or after rr_ptr.
module prio_rr_pick #(
   parameter int N_REQ  = 4,
   parameter int PRIO_W = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*PRIO_W-1:0]  prio,
   input  logic [$clog2(N_REQ)-1:0] rr_ptr,
   output logic                     found,
   output logic [$clog2(N_REQ)-1:0] index
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [PRIO_W-1:0] prio_arr [N_REQ];
   logic [PRIO_W-1:0] best_prio;
   logic [IDX_W-1:0]  cand;
   logic              hit;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign prio_arr[gi] = prio[gi*PRIO_W +: PRIO_W];
      end
   endgenerate

   always_comb begin : p_best
      best_prio = '0;
      found     = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i] && (!found || (prio_arr[i] > best_prio))) begin
            best_prio = prio_arr[i];
            found     = 1'b1;
         end
      end
   end

   // N_REQ is a power of two, so the index sum wraps naturally.
   always_comb begin : p_scan
      index = '0;
      hit   = 1'b0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = rr_ptr + IDX_W'(k);
         if (!hit && req[cand] && (prio_arr[cand] == best_prio)) begin
            index = cand;
            hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_rr_scheduler.sv
// Priority scheduler with round-robin tie breaking and time slicing.
// Optional preemption by a strictly higher priority: define SCHED_PREEMPT_EN.
module priority_rr_scheduler
   import priority_rr_scheduler_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int PRIO_W  = DEF_PRIO_W,
   parameter int QUANTUM = DEF_QUANTUM
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*PRIO_W-1:0]  prio,
   input  logic                     done,
   output logic [N_REQ-1:0]         grant,
   output logic                     grant_valid,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic [PRIO_W-1:0]        grant_prio,
   output logic                     slice_expired
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(QUANTUM);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(QUANTUM - 1);

   sched_state_e      state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic [PRIO_W-1:0] grant_prio_q, grant_prio_d;
   logic              slice_expired_q, slice_expired_d;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_index;
   logic [PRIO_W-1:0] pick_prio;
   logic              owner_req;
   logic              quantum_out;
   logic              preempt;
   logic              slice_end;

   prio_rr_pick #(
      .N_REQ  (N_REQ),
      .PRIO_W (PRIO_W)
   ) u_pick (
      .req    (req),
      .prio   (prio),
      .rr_ptr (rr_ptr_q),
      .found  (pick_found),
      .index  (pick_index)
   );

   assign pick_prio   = prio[pick_index*PRIO_W +: PRIO_W];
   assign owner_req   = req[grant_id_q];
   assign quantum_out = (cnt_q == '0);

`ifdef SCHED_PREEMPT_EN
   logic [N_REQ-1:0] outranks;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_preempt
         assign outranks[gi] = req[gi] && (prio[gi*PRIO_W +: PRIO_W] > grant_prio_q);
      end
   endgenerate

   assign preempt = |outranks;
`else
   assign preempt = 1'b0;
`endif

   assign slice_end = done || quantum_out || !owner_req || preempt;

   always_comb begin : p_next
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      cnt_d           = cnt_q;
      grant_d         = grant_q;
      grant_id_d      = grant_id_q;
      grant_prio_d    = grant_prio_q;
      slice_expired_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = ARB;
            end
         end

         ARB: begin
            if (pick_found) begin
               grant_d             = '0;
               grant_d[pick_index] = 1'b1;
               grant_id_d          = pick_index;
               grant_prio_d        = pick_prio;
               cnt_d               = CNT_LOAD;
               state_d             = RUN;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            if (slice_end) begin
               // Expiry is reported only when nothing else ended the slice.
               slice_expired_d = quantum_out && !done && owner_req && !preempt;
               rr_ptr_d        = grant_id_q + 1'b1;
               grant_d         = '0;
               grant_id_d      = '0;
               grant_prio_d    = '0;
               cnt_d           = '0;
               state_d         = (|req) ? ARB : IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin : p_regs
      if (rst) begin
         state_q         <= IDLE;
         rr_ptr_q        <= '0;
         cnt_q           <= '0;
         grant_q         <= '0;
         grant_id_q      <= '0;
         grant_prio_q    <= '0;
         slice_expired_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         cnt_q           <= cnt_d;
         grant_q         <= grant_d;
         grant_id_q      <= grant_id_d;
         grant_prio_q    <= grant_prio_d;
         slice_expired_q <= slice_expired_d;
      end
   end

   assign grant         = grant_q;
   assign grant_valid   = (state_q == RUN);
   assign grant_id      = grant_id_q;
   assign grant_prio    = grant_prio_q;
   assign slice_expired = slice_expired_q;

endmodule

// File: tb/tb_priority_rr_scheduler.sv
// Self-checking bench for priority_rr_scheduler: directed scenarios plus
// randomized traffic compared cycle by cycle against a slice-level model.
module tb_priority_rr_scheduler;

   localparam int N = 4;
   localparam int W = 4;
   localparam int Q = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] prio;
   logic           done;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [1:0]     grant_id;
   logic [W-1:0]   grant_prio;
   logic           slice_expired;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: is a task running, is an arbitration due, who owns the slice,
   // how many cycles of the slice have elapsed, and where ties start.
   bit m_running, m_arb_due, m_expired;
   int m_owner, m_owner_prio, m_used, m_ptr;

   priority_rr_scheduler #(
      .N_REQ   (N),
      .PRIO_W  (W),
      .QUANTUM (Q)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .prio          (prio),
      .done          (done),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .grant_prio    (grant_prio),
      .slice_expired (slice_expired)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int prio_of(input logic [N*W-1:0] p, input int i);
      return int'((p >> (i * W)) & ((1 << W) - 1));
   endfunction

   function automatic logic [N*W-1:0] make_prio(input int p0, input int p1, input int p2, input int p3);
      return {4'(p3), 4'(p2), 4'(p1), 4'(p0)};
   endfunction

   task automatic model_step();
      int  best;
      int  idx;
      bit  pre;
      bit  tout;
      bit  got;
      if (rst) begin
         m_running = 0; m_arb_due = 0; m_expired = 0;
         m_owner = 0; m_owner_prio = 0; m_used = 0; m_ptr = 0;
         return;
      end
      m_expired = 0;
      if (m_running) begin
         pre = 0;
`ifdef SCHED_PREEMPT_EN
         for (int i = 0; i < N; i++)
            if (req[i] && prio_of(prio, i) > m_owner_prio) pre = 1;
`endif
         tout = (m_used == Q);
         if (done || tout || !req[m_owner] || pre) begin
            m_expired = tout && !done && req[m_owner] && !pre;
            m_ptr     = (m_owner + 1) % N;
            m_running = 0;
            m_arb_due = (req != 0);
         end else begin
            m_used++;
         end
      end else if (m_arb_due) begin
         if (req == 0) begin
            m_arb_due = 0;
         end else begin
            best = -1;
            for (int i = 0; i < N; i++)
               if (req[i] && prio_of(prio, i) > best) best = prio_of(prio, i);
            got = 0;
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (!got && req[idx] && prio_of(prio, idx) == best) begin
                  m_owner = idx;
                  got = 1;
               end
            end
            m_owner_prio = best;
            m_running    = 1;
            m_arb_due    = 0;
            m_used       = 1;
         end
      end else begin
         m_arb_due = (req != 0);
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, compare after it.
   task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] p, input logic d, input logic rs);
      req = r; prio = p; done = d; rst = rs;
      @(posedge clk);
      model_step();
      #1;
      check_eq("grant_valid", grant_valid, m_running);
      check_eq("grant", grant, m_running ? (1 << m_owner) : 0);
      check_eq("grant_id", grant_id, m_running ? m_owner : 0);
      check_eq("grant_prio", grant_prio, m_running ? m_owner_prio : 0);
      check_eq("slice_expired", slice_expired, m_expired);
   endtask

   initial begin
      int             age;
      int             vcnt;
      int             ids[$];
      int             exp_ids[5] = '{0, 1, 2, 3, 0};
      int             cnt0, cnt1;
      bit             seen;
      logic [N-1:0]   r;
      logic [N*W-1:0] p;
      logic [W-1:0]   pv;

      rst = 1'b1; req = '0; prio = '0; done = 1'b0;

      // Reset state
      cycle(4'b0000, '0, 1'b0, 1'b1);
      cycle(4'b0000, '0, 1'b0, 1'b1);
      check_eq("rst_valid", grant_valid, 0);
      check_eq("rst_grant", grant, 0);

      // Single requester, quantum expiry and re-grant
      p = make_prio(0, 0, 5, 0);
      cycle(4'b0100, p, 1'b0, 1'b0);
      check_eq("r029_arb_gap", grant_valid, 0);
      cycle(4'b0100, p, 1'b0, 1'b0);
      check_eq("r029_grant", grant, 4'b0100);
      check_eq("r029_id", grant_id, 2);
      check_eq("r029_prio", grant_prio, 5);
      vcnt = 1;
      for (int t = 0; t < 20 && grant_valid; t++) begin
         cycle(4'b0100, p, 1'b0, 1'b0);
         if (grant_valid) vcnt++;
      end
      check_eq("r029_slice_len", vcnt, Q);
      check_eq("r029_expired", slice_expired, 1);
      cycle(4'b0100, p, 1'b0, 1'b0);
      check_eq("r029_regrant", {grant_valid, 2'(grant_id)}, {1'b1, 2'd2});

      // Equal priorities rotate round-robin
      cycle(4'b0000, '0, 1'b0, 1'b1);
      p = make_prio(3, 3, 3, 3);
      age = 0;
      for (int t = 0; t < 60 && ids.size() < 5; t++) begin
         cycle(4'b1111, p, (age == 2), 1'b0);
         age = grant_valid ? age + 1 : 0;
         if (age == 1) ids.push_back(int'(grant_id));
      end
      check_eq("r030_count", ids.size(), 5);
      for (int i = 0; i < ids.size() && i < 5; i++)
         check_eq("r030_order", ids[i], exp_ids[i]);

      // Higher priority keeps winning until it withdraws
      cycle(4'b0000, '0, 1'b0, 1'b1);
      p = make_prio(2, 9, 0, 0);
      cnt0 = 0; cnt1 = 0;
      for (int t = 0; t < 40; t++) begin
         cycle(4'b0011, p, 1'b0, 1'b0);
         if (grant_valid && grant_id == 0) cnt0++;
         if (grant_valid && grant_id == 1) cnt1++;
      end
      check_eq("r031_no_low", cnt0, 0);
      check_eq("r031_high_won", (cnt1 > 0), 1);
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
         cycle(4'b0001, p, 1'b0, 1'b0);
         if (grant_valid && grant_id == 0) seen = 1;
      end
      check_eq("r031_low_after_drop", seen, 1);

      // done coinciding with the last quantum cycle: no expiry pulse
      cycle(4'b0000, '0, 1'b0, 1'b1);
      p = make_prio(4, 0, 0, 0);
      age = 0; seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (age == Q) begin
            cycle(4'b0001, p, 1'b1, 1'b0);
            check_eq("r032_ended", grant_valid, 0);
            check_eq("r032_no_pulse", slice_expired, 0);
            seen = 1;
         end else begin
            cycle(4'b0001, p, 1'b0, 1'b0);
            age = grant_valid ? age + 1 : 0;
         end
      end
      check_eq("r032_reached", seen, 1);
      cycle(4'b0001, p, 1'b0, 1'b0);
      check_eq("r032_regrant", grant_valid, 1);

      // Reset in the middle of a slice
      cycle(4'b0000, '0, 1'b0, 1'b1);
      p = make_prio(1, 0, 0, 6);
      age = 0;
      for (int t = 0; t < 20 && age < 5; t++) begin
         cycle(4'b0001, p, 1'b0, 1'b0);
         age = grant_valid ? age + 1 : 0;
      end
      cycle(4'b1000, p, 1'b0, 1'b1);
      check_eq("r033_rst_outputs", {grant, grant_valid, 2'(grant_id), grant_prio, slice_expired}, 0);
      cycle(4'b1000, p, 1'b0, 1'b0);
      cycle(4'b1000, p, 1'b0, 1'b0);
      check_eq("r033_grant3", {grant_valid, 2'(grant_id)}, {1'b1, 2'd3});

      // Higher-priority arrival during a running slice
      cycle(4'b0000, '0, 1'b0, 1'b1);
      p = make_prio(2, 0, 0, 7);
      for (int t = 0; t < 5 && !grant_valid; t++)
         cycle(4'b0001, p, 1'b0, 1'b0);
      check_eq("r034_owner0", {grant_valid, 2'(grant_id)}, {1'b1, 2'd0});
      cycle(4'b1001, p, 1'b0, 1'b0);
`ifdef SCHED_PREEMPT_EN
      check_eq("r034_preempted", grant_valid, 0);
      check_eq("r034_no_pulse", slice_expired, 0);
      cycle(4'b1001, p, 1'b0, 1'b0);
      check_eq("r034_grant3", {grant_valid, 2'(grant_id)}, {1'b1, 2'd3});
`else
      vcnt = 1;
      for (int t = 0; t < 20 && grant_valid; t++) begin
         if (grant_valid) vcnt++;
         cycle(4'b1001, p, 1'b0, 1'b0);
      end
      check_eq("r034_full_quantum", vcnt, Q);
      cycle(4'b1001, p, 1'b0, 1'b0);
      check_eq("r034_then3", {grant_valid, 2'(grant_id)}, {1'b1, 2'd3});
`endif

      // Randomized traffic against the model
      r = 4'b0000;
      p = 16'($urandom);
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 11) == 0) r = 4'($urandom);
         if ($urandom_range(0, 9) == 0) p = 16'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            pv = 4'($urandom);
            p = {4{pv}};
         end
         cycle(r, p, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
